// File: rtl/ss_pkg.sv
// Shared types and constants for the serial frame deserializer.
// Also provides the one-bit shift rule used by the window/byte shifter.
package ss_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } ss_rx_state_t;

  localparam logic [7:0] SS_SYNC_DEFAULT = 8'hA5;
  localparam int         SS_BYTE_W       = 8;

  // MSB-first appends at bit 0 so the first bit ends in bit 7;
  // LSB-first enters at bit 7 so the first bit ends in bit 0.
  function automatic logic [SS_BYTE_W-1:0] ss_shift(
    input logic [SS_BYTE_W-1:0] cur,
    input logic                 bit_in,
    input bit                   msb_first
  );
    if (msb_first) ss_shift = {cur[SS_BYTE_W-2:0], bit_in};
    else           ss_shift = {bit_in, cur[SS_BYTE_W-1:1]};
  endfunction

endpackage

// File: rtl/ss_byte_shifter.sv
// 8-bit serial-to-parallel shifter with a 3-bit bit counter and byte strobe.
// Serves as the sync window in HUNT and as the byte assembler afterwards.
module ss_byte_shifter
  import ss_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift,
  input  logic                 bit_in,
  input  logic                 clear_cnt,
  input  logic                 clear_reg,
  output logic [SS_BYTE_W-1:0] next_data,
  output logic                 byte_done
);

  logic [SS_BYTE_W-1:0] data;
  logic [2:0]           cnt;

  // Post-shift value is exposed so the sync compare sees the bit being consumed.
  always_comb begin
    next_data = ss_shift(data, bit_in, MSB_FIRST);
    byte_done = shift && (cnt == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      if (clear_reg)  data <= '0;
      else if (shift) data <= next_data;

      if (clear_cnt)  cnt <= '0;
      else if (shift) cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/ss_frame_deserializer.sv
// Hunts for a sync word in a serial stream, assembles payload bytes and
// verifies the trailing XOR checksum; all outputs are registered.
module ss_frame_deserializer
  import ss_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD     = SS_SYNC_DEFAULT,
  parameter int         PAYLOAD_BYTES = 4,
  parameter bit         MSB_FIRST     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam logic [3:0] LAST_BYTE = 4'(PAYLOAD_BYTES - 1);

  ss_rx_state_t         state;
  logic [3:0]           byte_cnt;
  logic [SS_BYTE_W-1:0] csum;

  logic [SS_BYTE_W-1:0] next_byte;
  logic                 byte_done;
  logic                 sync_hit;
  logic                 check_done;

  always_comb begin
    sync_hit   = ena && (state == HUNT) && (next_byte == SYNC_WORD);
    check_done = (state == CHECK) && byte_done;
  end

  // The window is wiped after the checksum so a new sync needs 8 fresh bits.
  ss_byte_shifter #(
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift     (ena),
    .bit_in    (serial_in),
    .clear_cnt (sync_hit),
    .clear_reg (check_done),
    .next_data (next_byte),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HUNT;
      byte_cnt   <= '0;
      csum       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      if (ena) begin
        case (state)
          HUNT: begin
            if (sync_hit) begin
              state    <= PAYLOAD;
              locked   <= 1'b1;
              byte_cnt <= '0;
              csum     <= '0;
            end
          end
          PAYLOAD: begin
            if (byte_done) begin
              data_out   <= next_byte;
              data_valid <= 1'b1;
              csum       <= csum ^ next_byte;
              byte_cnt   <= byte_cnt + 4'd1;
              if (byte_cnt == LAST_BYTE) state <= CHECK;
            end
          end
          CHECK: begin
            if (byte_done) begin
              frame_ok  <= (next_byte == csum);
              frame_err <= (next_byte != csum);
              state     <= HUNT;
              locked    <= 1'b0;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ss_frame_deserializer.md
# ss_frame_deserializer

Downstream consumer of the serial-in/serial-out register's `data_out` bit stream. Hunts for a sync word in the serial stream and assembles the following payload bits into parallel bytes. Verifies a trailing XOR checksum and reports frame status. Sits between the shift-register stage and any parallel sink, such as `uo_out` or a bidirectional port.

## Interface
Parameters:
- `SYNC_WORD`, 8'hA5: 8-bit frame delimiter.
- `PAYLOAD_BYTES`, 4: payload bytes per frame; legal range 1..15.
- `MSB_FIRST`, 1: 1 = first received bit of a byte lands in bit 7; 0 = first bit lands in bit 0.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  bit-enable; one serial bit is consumed per rising edge with `ena`=1.
- `serial_in`  in  1  serial bit stream, driven from the shift register's `data_out`.
- `data_out`  out  8  last assembled payload byte.
- `data_valid`  out  1  one-cycle pulse: `data_out` holds a new payload byte.
- `locked`  out  1  high while a frame is in progress (state ≠ HUNT).
- `frame_ok`  out  1  one-cycle pulse: received checksum matched.
- `frame_err`  out  1  one-cycle pulse: received checksum mismatched.

## Operation
- The reset state is HUNT.
- Reset clears the window, bit counter, byte counter and checksum.
- All outputs reset to 0.
- On every edge with `ena`=0, all state and `data_out` hold.
- All pulses deassert on that edge.
- States:
  - **HUNT**: each enabled bit shifts an 8-bit sliding window.
    - MSB_FIRST=1: window = {window[6:0], bit}.
    - MSB_FIRST=0: window = {bit, window[7:1]}.
    - When the post-shift window equals `SYNC_WORD`, go to PAYLOAD.
    - On that transition, clear the bit counter, byte counter and checksum.
  - **PAYLOAD**: assemble bits into a byte with the same shift rule.
    - On the 8th bit, load `data_out` with the byte and pulse `data_valid`.
    - Update checksum ^= byte and increment the byte counter.
    - After byte `PAYLOAD_BYTES`, go to CHECK.
  - **CHECK**: assemble 8 bits.
    - On the 8th bit, pulse `frame_ok` if the byte equals the checksum, else `frame_err`.
    - Clear the window to 0 and go to HUNT.
- After a frame, sync needs 8 fresh bits; no overlap with the checksum bits.
- Sync bits inside the payload or checksum are ignored, because detection happens only in HUNT.
- `locked` = (state == PAYLOAD or CHECK), registered.
- `data_out` holds its value until the next payload byte; it is not cleared at frame end.
- `rst_n`=0 mid-frame: the next edge returns to HUNT with all outputs 0. Reset has priority over `ena`.
- Arithmetic widths:
  - bit counter: 3 bits, wraps 7→0 at byte completion.
  - byte counter: 4 bits.
  - checksum: 8 bits.

## Timing
- Latency: outputs are registered and asserted in the cycle after the edge that consumes the relevant bit.
  - `data_valid` follows the 8th bit of a byte.
  - `frame_ok`/`frame_err` follow the 8th checksum bit.
- `locked` rises in the cycle after the edge that completes the sync word.
- `locked` falls in the same cycle that `frame_ok`/`frame_err` is visible.
- Pulses are exactly one cycle wide, even if `ena` stays high.
- Back-to-back bytes at `ena`=1 every cycle give `data_valid` every 8th cycle.
- Gaps in `ena` stretch spacing without losing bits.
- `frame_ok` and `frame_err` are never high together.
- `data_valid` never coincides with either frame pulse.

## Structure
- Shared package `ss_pkg`:
  - state enum `ss_rx_state_t` {HUNT, PAYLOAD, CHECK}.
  - constant `SS_SYNC_DEFAULT` = 8'hA5.
  - constant `SS_BYTE_W` = 8.
- One natural sub-module: `ss_byte_shifter`.
  - Contains the 8-bit shift register with MSB_FIRST select, the 3-bit counter and the `byte_done` strobe.
  - It is reused for the window, the payload and the checksum.
  - Its counter is cleared by the FSM.

## Test plan
- **Nominal frame.** Reset, then `ena`=1 with MSB-first serial A5, 01, 02, 03, 04, 04.
  - `data_valid` ×4 with `data_out` = 01, 02, 03, 04.
  - Then `frame_ok`=1 for one cycle and `locked`=0.
- **Bad checksum.** Same frame with checksum 05.
  - 4 bytes delivered, then `frame_err` pulse, no `frame_ok`, back to HUNT.
- **Misaligned sync.** Bits 1,1,0 followed by A5 and a valid frame.
  - Sync is found after the 11th bit, and payload bytes are exact.
  - A5 embedded in the payload is delivered as data, not re-synced.
- **ena gaps.** Nominal frame with `ena` toggling 1,0,0,1 pattern.
  - Identical `data_out` sequence and `frame_ok`.
  - No output changes on `ena`=0 edges.
- **Reset mid-frame.** `rst_n`=0 for one edge after byte 2.
  - All outputs 0 and `locked`=0 next cycle.
  - A subsequent full frame decodes correctly.
- **LSB-first.** `MSB_FIRST`=0, `PAYLOAD_BYTES`=1, stream bit-reversed A5, 3C, 3C.
  - `data_out`=3C, then `frame_ok`.
